phase_error_sequencer: RTL and testbench

//  Pairs single-cycle edge pulses from the reference and feedback falling-edge detectors.

---
 rtl/phase_error_sequencer_pkg.sv | 28 ++
 rtl/phase_error_sequencer_lock_detector.sv | 65 ++++++
 rtl/phase_error_sequencer.sv | 168 ++++++++++++++++
 tb/tb_phase_error_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_error_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phase_error_sequencer_pkg
// Purpose  : Definitions shared by the ADPLL phase-error path: sequencer state
//            encoding, default counter width and the error-width rule that the
//            loop filter also relies on.
// Revision : 1.0
// ============================================================================
package phase_error_sequencer_pkg;

  // Default magnitude counter width for the phase measurement.
  localparam int CNT_W_DEF = 16;

  // Sequencer states; the encodings are shared with software/debug views.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REF_LEAD = 2'd1,
    ST_FB_LEAD  = 2'd2,
    ST_HOLD     = 2'd3
  } seq_state_t;

  // Signed error width: one sign bit on top of the magnitude counter.
  function automatic int err_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_error_sequencer_lock_detector.sv
`default_nettype none
// ============================================================================
// Module   : adpll_lock_detector
// Purpose  : Counts consecutive accepted in-window phase results and raises a
//            lock flag once LOCK_N of them arrive back to back. A timeout, an
//            out-of-window result or a cycle slip restarts the run.
// Revision : 1.0
// ============================================================================
module adpll_lock_detector #(
  parameter int ERR_W    = 17,
  parameter int LOCK_WIN = 4,
  parameter int LOCK_N   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_accept,
  input  logic signed [ERR_W-1:0] i_err,
  input  logic                    i_timeout,
  input  logic                    i_slip,
  output logic                    o_lock
);

  localparam int RUN_W = $clog2(LOCK_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_N);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [ERR_W-1:0] WIN_LIM = ERR_W'(LOCK_WIN);

  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic [ERR_W-1:0] w_abs;
  logic             w_in_win;
  logic             r_lock;

  assign w_abs    = i_err[ERR_W-1] ? -i_err : i_err;
  assign w_in_win = !i_timeout && (w_abs <= WIN_LIM);

  // Next run length: slip restarts, accepted results extend or restart, saturating at LOCK_N.
  always_comb begin
    w_run_nxt = r_run;
    if (i_slip) begin
      w_run_nxt = '0;
    end else if (i_accept) begin
      if (w_in_win) begin
        w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;
      end else begin
        w_run_nxt = '0;
      end
    end
  end

  // Run counter and registered lock flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run  <= '0;
      r_lock <= 1'b0;
    end else begin
      r_run  <= w_run_nxt;
      r_lock <= (w_run_nxt == RUN_MAX);
    end
  end

  assign o_lock = r_lock;

endmodule
`default_nettype wire

// File: rtl/phase_error_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_error_sequencer
// Purpose  : Pairs reference and feedback edge pulses, measures their
//            separation in clock cycles and presents a signed phase error to
//            the loop filter over a valid/ready handshake.
//            Optional lock detection is built when ADPLL_LOCK_DETECT_EN is
//            defined; otherwise lock_o is tied low.
// Revision : 1.0
// ============================================================================
module phase_error_sequencer
  import phase_error_sequencer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_WIN = 4,
  parameter int LOCK_N   = 8
) (
  input  logic                             fpga_clk_i,
  input  logic                             rst_n_i,
  input  logic                             enable_i,
  input  logic                             ref_edge_i,
  input  logic                             fb_edge_i,
  output logic signed [err_width(CNT_W)-1:0] err_o,
  output logic                             err_valid_o,
  input  logic                             err_ready_i,
  output logic                             timeout_o,
  output logic                             slip_o,
  output logic                             busy_o,
  output logic                             lock_o
);

  localparam int ERR_W = err_width(CNT_W);
  localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_t              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_valid;
  logic                    r_timeout;
  logic                    r_slip;
  logic                    r_busy;

  logic                    w_from_ref;
  logic                    w_lead_edge;
  logic                    w_partner_edge;
  logic signed [ERR_W-1:0] w_cnt_pos;
  logic signed [ERR_W-1:0] w_cnt_neg;
  logic signed [ERR_W-1:0] w_signed_cnt;

  // Which edge opened the measurement decides the sign and the roles of the inputs.
  assign w_from_ref     = (r_state == ST_REF_LEAD);
  assign w_lead_edge    = w_from_ref ? ref_edge_i : fb_edge_i;
  assign w_partner_edge = w_from_ref ? fb_edge_i  : ref_edge_i;
  assign w_cnt_pos      = {1'b0, r_cnt};
  assign w_cnt_neg      = -w_cnt_pos;
  assign w_signed_cnt   = w_from_ref ? w_cnt_pos : w_cnt_neg;

  // Measurement sequencer; every output is a register updated here.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_err     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_slip    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_slip <= 1'b0;
      if (!enable_i) begin
        // Abandon any measurement or pending result; err/timeout keep their last value.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (ref_edge_i && fb_edge_i) begin
              r_err     <= '0;
              r_timeout <= 1'b0;
              r_valid   <= 1'b1;
              r_state   <= ST_HOLD;
            end else if (ref_edge_i) begin
              r_cnt   <= CNT_ONE;
              r_busy  <= 1'b1;
              r_state <= ST_REF_LEAD;
            end else if (fb_edge_i) begin
              r_cnt   <= CNT_ONE;
              r_busy  <= 1'b1;
              r_state <= ST_FB_LEAD;
            end
          end
          ST_REF_LEAD, ST_FB_LEAD: begin
            if (w_partner_edge) begin
              // Partner takes priority even when the leading edge repeats in the same cycle.
              r_err     <= w_signed_cnt;
              r_timeout <= 1'b0;
              r_valid   <= 1'b1;
              r_busy    <= 1'b0;
              r_cnt     <= '0;
              r_state   <= ST_HOLD;
            end else if (w_lead_edge) begin
              // Cycle slip: restart timing from the newer leading edge.
              r_slip <= 1'b1;
              r_cnt  <= CNT_ONE;
            end else if (r_cnt == MAX_CNT) begin
              // Saturate rather than wrap; report the full-scale error flagged as timeout.
              r_err     <= w_signed_cnt;
              r_timeout <= 1'b1;
              r_valid   <= 1'b1;
              r_busy    <= 1'b0;
              r_cnt     <= '0;
              r_state   <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_HOLD: begin
            // Edges arriving here are dropped; only the handshake moves us on.
            if (err_ready_i) begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign err_o       = r_err;
  assign err_valid_o = r_valid;
  assign timeout_o   = r_timeout;
  assign slip_o      = r_slip;
  assign busy_o      = r_busy;

`ifdef ADPLL_LOCK_DETECT_EN
  logic w_accept;

  // A result counts toward lock only when actually handed to the loop filter.
  assign w_accept = r_valid & err_ready_i & enable_i;

  adpll_lock_detector #(
    .ERR_W    (ERR_W),
    .LOCK_WIN (LOCK_WIN),
    .LOCK_N   (LOCK_N)
  ) u_lock_detector (
    .i_clk     (fpga_clk_i),
    .i_rst_n   (rst_n_i),
    .i_accept  (w_accept),
    .i_err     (r_err),
    .i_timeout (r_timeout),
    .i_slip    (r_slip),
    .o_lock    (lock_o)
  );
`else
  logic w_unused_cfg;

  assign w_unused_cfg = ^{LOCK_WIN, LOCK_N};
  assign lock_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_error_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_error_sequencer
// Purpose  : Self-checking bench for phase_error_sequencer (CNT_W=4,
//            LOCK_WIN=1, LOCK_N=3). An edge-timestamp model predicts every
//            output each cycle; directed scenarios pin literal values.
// Revision : 1.0
// ============================================================================
module tb_phase_error_sequencer;

  localparam int CNT_W    = 4;
  localparam int LOCK_WIN = 1;
  localparam int LOCK_N   = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;
`ifdef ADPLL_LOCK_DETECT_EN
  localparam int LOCK_EN  = 1;
`else
  localparam int LOCK_EN  = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic ref_e = 1'b0;
  logic fb_e  = 1'b0;
  logic ready = 1'b1;

  logic signed [CNT_W:0] err;
  logic valid, tmo, slip, busy, lock;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  phase_error_sequencer #(
    .CNT_W    (CNT_W),
    .LOCK_WIN (LOCK_WIN),
    .LOCK_N   (LOCK_N)
  ) dut (
    .fpga_clk_i  (clk),
    .rst_n_i     (rst_n),
    .enable_i    (enable),
    .ref_edge_i  (ref_e),
    .fb_edge_i   (fb_e),
    .err_o       (err),
    .err_valid_o (valid),
    .err_ready_i (ready),
    .timeout_o   (tmo),
    .slip_o      (slip),
    .busy_o      (busy),
    .lock_o      (lock)
  );

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (edge timestamps) ----------------
  int m_cyc, m_t0, m_err, m_run, m_age;
  bit m_busy, m_lead_fb, m_hold, m_to, m_slip, m_lock, m_partner, m_again;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cyc = 0; m_t0 = 0; m_err = 0; m_run = 0;
        m_busy = 0; m_lead_fb = 0; m_hold = 0; m_to = 0; m_slip = 0; m_lock = 0;
      end else begin
        m_cyc++;
        if (LOCK_EN != 0) begin
          if (m_slip) begin
            m_run = 0;
          end else if (enable && m_hold && ready) begin
            if (!m_to && (m_err <= LOCK_WIN) && (m_err >= -LOCK_WIN))
              m_run = (m_run < LOCK_N) ? m_run + 1 : LOCK_N;
            else
              m_run = 0;
          end
          m_lock = (m_run == LOCK_N);
        end
        m_slip = 0;
        if (!enable) begin
          m_hold = 0;
          m_busy = 0;
        end else if (m_hold) begin
          if (ready) m_hold = 0;
        end else if (m_busy) begin
          m_partner = m_lead_fb ? ref_e : fb_e;
          m_again   = m_lead_fb ? fb_e : ref_e;
          m_age     = m_cyc - m_t0;
          if (m_partner) begin
            m_err = m_lead_fb ? -m_age : m_age;
            m_to = 0; m_hold = 1; m_busy = 0;
          end else if (m_again) begin
            m_slip = 1;
            m_t0 = m_cyc;
          end else if (m_age == MAXC) begin
            m_err = m_lead_fb ? -MAXC : MAXC;
            m_to = 1; m_hold = 1; m_busy = 0;
          end
        end else if (ref_e && fb_e) begin
          m_err = 0; m_to = 0; m_hold = 1;
        end else if (ref_e || fb_e) begin
          m_busy = 1;
          m_lead_fb = fb_e;
          m_t0 = m_cyc;
        end
      end
      #1;
      check("m_valid", valid, m_hold);
      check("m_busy", busy, m_busy);
      check("m_slip", slip, m_slip);
      check("m_err", err, m_err);
      check("m_timeout", tmo, m_to);
      check("m_lock", lock, m_lock);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse(input logic r, input logic f);
    ref_e = r;
    fb_e  = f;
    @(negedge clk);
    ref_e = 1'b0;
    fb_e  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_err", err, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lock", lock, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ref leads fb by 5
    pulse(1, 0);
    repeat (4) @(negedge clk);
    check("A_pre_valid", valid, 0);
    pulse(0, 1);
    check("A_valid", valid, 1);
    check("A_err", err, 5);
    check("A_tmo", tmo, 0);
    @(negedge clk);
    check("A_after_accept", valid, 0);

    // fb leads ref by 3
    pulse(0, 1);
    repeat (2) @(negedge clk);
    pulse(1, 0);
    check("B_err", err, -3);
    @(negedge clk);

    // simultaneous edges
    pulse(1, 1);
    check("C_valid", valid, 1);
    check("C_err", err, 0);
    @(negedge clk);

    // timeout, no wrap
    pulse(1, 0);
    repeat (14) @(negedge clk);
    check("D_pre_valid", valid, 0);
    check("D_busy", busy, 1);
    @(negedge clk);
    check("D_valid", valid, 1);
    check("D_err", err, 15);
    check("D_tmo", tmo, 1);
    @(negedge clk);

    // slip: ref t, ref t+4, fb t+6
    pulse(1, 0);
    repeat (3) @(negedge clk);
    pulse(1, 0);
    check("E_slip", slip, 1);
    @(negedge clk);
    check("E_slip_end", slip, 0);
    pulse(0, 1);
    check("E_err", err, 2);
    check("E_valid", valid, 1);
    @(negedge clk);

    // stalled HOLD with extra edges
    ready = 1'b0;
    pulse(1, 0);
    repeat (2) @(negedge clk);
    pulse(0, 1);
    check("F_err", err, 3);
    for (int i = 0; i < 10; i++) begin
      ref_e = i[0];
      fb_e  = i[1];
      @(negedge clk);
      check("F_hold_valid", valid, 1);
      check("F_hold_err", err, 3);
    end
    ref_e = 1'b0;
    fb_e  = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("F_accept_valid", valid, 0);
    @(negedge clk);
    check("F_idle_busy", busy, 0);

    // lock sequence +1, 0, -1 then +2
    pulse(1, 0);
    pulse(0, 1);
    check("G_err1", err, 1);
    @(negedge clk);
    pulse(1, 1);
    check("G_err0", err, 0);
    @(negedge clk);
    pulse(0, 1);
    pulse(1, 0);
    check("G_errm1", err, -1);
    check("G_lock_before", lock, 0);
    @(negedge clk);
    check("G_lock", lock, LOCK_EN);
    pulse(1, 0);
    @(negedge clk);
    pulse(0, 1);
    check("G_err2", err, 2);
    @(negedge clk);
    check("G_unlock", lock, 0);

    // enable low mid REF_LEAD
    pulse(1, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("H_busy", busy, 0);
    check("H_valid", valid, 0);
    check("H_err_kept", err, 2);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("H_no_valid", valid, 0);

    // enable low in HOLD discards the result
    ready = 1'b0;
    pulse(1, 1);
    check("H2_valid", valid, 1);
    enable = 1'b0;
    @(negedge clk);
    check("H2_discard", valid, 0);
    enable = 1'b1;
    ready  = 1'b1;
    @(negedge clk);

    // async reset in HOLD
    ready = 1'b0;
    pulse(1, 0);
    pulse(0, 1);
    check("I_valid", valid, 1);
    check("I_err", err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("I_rst_err", err, 0);
    check("I_rst_valid", valid, 0);
    check("I_rst_tmo", tmo, 0);
    check("I_rst_slip", slip, 0);
    check("I_rst_busy", busy, 0);
    check("I_rst_lock", lock, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
